// File: rtl/sw_lcd_page_sequencer.sv
// Stopwatch LCD page sequencer: snapshots the selected BCD time fields and streams
// two 16-char lines to the LCD writer. Define LCD_SEQ_ACK_TIMEOUT_EN for the ack watchdog.
module sw_lcd_page_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_1k,
   input  logic        rst_n,
   input  logic [1:0]  sw_lcd_mode,
   input  logic        sw_update_toggle,
   input  logic        lap_valid,
   input  logic [23:0] cur_bcd,
   input  logic [23:0] lap_bcd,
   input  logic [23:0] int_bcd,
   input  logic [23:0] best_bcd,
   input  logic [23:0] avg_bcd,
   input  logic        wr_ack,
   output logic        wr_req,
   output logic [4:0]  wr_addr,
   output logic [7:0]  wr_char,
   output logic        busy,
   output logic        frame_done,
   output logic        ack_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

   state_t      state_r, state_n;
   logic [4:0]  index_r, index_n;
   logic        pending_r, pending_n;
   logic        prev_toggle_r;
   logic [1:0]  prev_mode_r;
   logic [1:0]  snap_mode_r, snap_mode_n;
   logic        snap_lv_r, snap_lv_n;
   logic [23:0] snap_f1_r, snap_f1_n, snap_f2_r, snap_f2_n;
   logic        wr_req_r, wr_req_n;
   logic [4:0]  wr_addr_r, wr_addr_n;
   logic [7:0]  wr_char_r, wr_char_n;
   logic        busy_r, busy_n, frame_done_r, frame_done_n, ack_timeout_r, ack_timeout_n;
   logic        event_s, ack_s, timeout_s;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      if (d <= 4'd9) return 8'h30 | {4'h0, d};
      else return 8'h3F;
   endfunction

   function automatic logic [7:0] field_char(input logic [23:0] f, input logic [2:0] k, input logic dashed);
      logic [23:0] sh;
      sh = f << {k, 2'b00};
      if (dashed) return 8'h2D;
      else return digit_char(sh[23:20]);
   endfunction

   // Label text indexed by {line2, mode}; line 2 of page 0 is blank
   function automatic logic [23:0] label_str(input logic [2:0] sel);
      case (sel)
         3'b000, 3'b001: return 24'h435552;
         3'b010, 3'b101: return 24'h4C4150;
         3'b011:         return 24'h425354;
         3'b110:         return 24'h494E54;
         3'b111:         return 24'h415647;
         default:        return 24'h202020;
      endcase
   endfunction

   function automatic logic [7:0] render_char(input logic [1:0] mode, input logic lv,
                                              input logic [23:0] f1, input logic [23:0] f2,
                                              input logic [4:0] idx);
      logic        line2;
      logic [23:0] f;
      logic [23:0] lbl;
      logic        dashed;
      logic [7:0]  c;
      line2  = idx[4];
      f      = line2 ? f2 : f1;
      dashed = !lv && (line2 ? (mode != 2'd0) : mode[1]);
      lbl    = label_str({line2, mode});
      case (idx[3:0])
         4'd0:    c = lbl[23:16];
         4'd1:    c = lbl[15:8];
         4'd2:    c = lbl[7:0];
         4'd4:    c = field_char(f, 3'd0, dashed);
         4'd5:    c = field_char(f, 3'd1, dashed);
         4'd6:    c = 8'h3A;
         4'd7:    c = field_char(f, 3'd2, dashed);
         4'd8:    c = field_char(f, 3'd3, dashed);
         4'd9:    c = 8'h2E;
         4'd10:   c = field_char(f, 3'd4, dashed);
         4'd11:   c = field_char(f, 3'd5, dashed);
         default: c = 8'h20;
      endcase
      if (line2 && (mode == 2'd0)) return 8'h20;
      else return c;
   endfunction

   assign event_s = (sw_update_toggle != prev_toggle_r) || (sw_lcd_mode != prev_mode_r);
   assign ack_s   = (state_r == SEND) && wr_req_r && wr_ack;

`ifdef LCD_SEQ_ACK_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC);
   logic [7:0] wait_cnt_r, wait_cnt_n;

   // Watchdog: counts cycles a request sits unacknowledged
   always_comb begin
      wait_cnt_n = 8'd0;
      timeout_s  = 1'b0;
      if ((state_r == SEND) && wr_req_r && !wr_ack) begin
         wait_cnt_n = wait_cnt_r + 8'd1;
         timeout_s  = (wait_cnt_n == TIMEOUT_LIMIT);
         if (timeout_s) wait_cnt_n = 8'd0;
         else wait_cnt_n = wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_n = 8'd0;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) wait_cnt_r <= 8'd0;
      else wait_cnt_r <= wait_cnt_n;
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next state, index, refresh flag and snapshot
   always_comb begin
      state_n     = state_r;
      index_n     = index_r;
      snap_mode_n = snap_mode_r;
      snap_lv_n   = snap_lv_r;
      snap_f1_n   = snap_f1_r;
      snap_f2_n   = snap_f2_r;
      case (state_r)
         IDLE: begin
            if (pending_r) state_n = LOAD;
            else state_n = IDLE;
         end
         LOAD: begin
            state_n     = SEND;
            index_n     = 5'd0;
            snap_mode_n = sw_lcd_mode;
            snap_lv_n   = lap_valid;
            case (sw_lcd_mode)
               2'd1:    begin snap_f1_n = cur_bcd;  snap_f2_n = lap_bcd; end
               2'd2:    begin snap_f1_n = lap_bcd;  snap_f2_n = int_bcd; end
               2'd3:    begin snap_f1_n = best_bcd; snap_f2_n = avg_bcd; end
               default: begin snap_f1_n = cur_bcd;  snap_f2_n = 24'h000000; end
            endcase
         end
         SEND: begin
            if (timeout_s) begin
               state_n = IDLE;
               index_n = 5'd0;
            end else if (ack_s && (index_r == 5'd31)) begin
               state_n = DONE;
               index_n = 5'd0;
            end else if (ack_s) begin
               index_n = index_r + 5'd1;
            end else begin
               state_n = SEND;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Entering LOAD consumes the flag; the snapshot taken there already sees any same-cycle change
      if ((state_r == IDLE) && pending_r) pending_n = 1'b0;
      else if (event_s || timeout_s) pending_n = 1'b1;
      else pending_n = pending_r;
   end

   // Output values for the coming cycle, derived from the next state
   always_comb begin
      wr_req_n     = (state_n == SEND);
      wr_addr_n    = index_n;
      busy_n       = (state_n != IDLE);
      frame_done_n = (state_n == DONE);
      if (state_n == SEND) wr_char_n = render_char(snap_mode_n, snap_lv_n, snap_f1_n, snap_f2_n, index_n);
      else wr_char_n = 8'h20;
      if (timeout_s) ack_timeout_n = 1'b1;
      else if (state_n == DONE) ack_timeout_n = 1'b0;
      else ack_timeout_n = ack_timeout_r;
   end

   // State, snapshot and event-history registers
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         index_r       <= 5'd0;
         pending_r     <= 1'b1;
         prev_toggle_r <= 1'b0;
         prev_mode_r   <= 2'd0;
         snap_mode_r   <= 2'd0;
         snap_lv_r     <= 1'b0;
         snap_f1_r     <= 24'h000000;
         snap_f2_r     <= 24'h000000;
      end else begin
         state_r       <= state_n;
         index_r       <= index_n;
         pending_r     <= pending_n;
         prev_toggle_r <= sw_update_toggle;
         prev_mode_r   <= sw_lcd_mode;
         snap_mode_r   <= snap_mode_n;
         snap_lv_r     <= snap_lv_n;
         snap_f1_r     <= snap_f1_n;
         snap_f2_r     <= snap_f2_n;
      end
   end

   // Output registers
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         wr_req_r      <= 1'b0;
         wr_addr_r     <= 5'd0;
         wr_char_r     <= 8'h20;
         busy_r        <= 1'b0;
         frame_done_r  <= 1'b0;
         ack_timeout_r <= 1'b0;
      end else begin
         wr_req_r      <= wr_req_n;
         wr_addr_r     <= wr_addr_n;
         wr_char_r     <= wr_char_n;
         busy_r        <= busy_n;
         frame_done_r  <= frame_done_n;
         ack_timeout_r <= ack_timeout_n;
      end
   end

   assign wr_req      = wr_req_r;
   assign wr_addr     = wr_addr_r;
   assign wr_char     = wr_char_r;
   assign busy        = busy_r;
   assign frame_done  = frame_done_r;
   assign ack_timeout = ack_timeout_r;

endmodule

// File: doc/sw_lcd_page_sequencer.md
# sw_lcd_page_sequencer

Sequences the stopwatch results onto the 2x16 character LCD. It watches the stopwatch controller's `sw_lcd_mode` and `sw_update_toggle` outputs. On every change it snapshots the selected BCD time fields, renders two 16-character lines, and streams all 32 characters to the LCD character writer over a req/ack handshake. It sits between the stopwatch controller and the LCD writer, and is the only master of the writer while stopwatch mode is active.

## Interface
Parameters:
- `TIMEOUT_CYC`, 255: number of cycles `wr_req` may wait for `wr_ack` before a timeout. Used only when `LCD_SEQ_ACK_TIMEOUT_EN` is defined.

Ports:
- `clk_1k` in 1: system clock, 1 kHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_lcd_mode` in 2: page select from the stopwatch controller.
- `sw_update_toggle` in 1: level toggles whenever the stopwatch data changes.
- `lap_valid` in 1: at least one lap has been recorded.
- `cur_bcd`, `lap_bcd`, `int_bcd`, `best_bcd`, `avg_bcd` in 24 each: time fields packed {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}, 4 bits per digit, MSB first.
- `wr_ack` in 1: the writer has accepted the current character.
- `wr_req` out 1: character valid.
- `wr_addr` out 5: LCD position. 0-15 is line 1, 16-31 is line 2.
- `wr_char` out 8: ASCII code.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last character is accepted.
- `ack_timeout` out 1: sticky error flag.

## Operation
- **Refresh event.** An event is any change of `sw_update_toggle` or of `sw_lcd_mode` versus its value registered on the previous cycle. The refresh flag `pending` is set by an event and cleared when LOAD is entered. Reset sets `pending`=1 so the screen is drawn on power-up.
- **FSM states:**
  - IDLE → LOAD when `pending`.
  - LOAD: snapshot `sw_lcd_mode`, `lap_valid` and the needed fields in one cycle, then go to SEND with index=0.
  - SEND: drive `wr_req`=1, `wr_addr`=index and `wr_char` from the snapshot.
    - On `wr_ack` at index<31: index+1.
    - On `wr_ack` at index 31: go to DONE.
  - DONE: pulse `frame_done`, then go to IDLE. If `pending` is already set, IDLE passes straight to LOAD on the next cycle.
- **Coherence.** Events during LOAD, SEND or DONE only set `pending`. Any number of events during one frame produces exactly one follow-up frame. The snapshot is never updated mid-frame.
- **Line format.** Each line is a 3-char label, a space, `mm:ss.cc`, then 4 spaces (0x20).
  - Mode 0: line 1 `CUR`, line 2 all spaces.
  - Mode 1: line 1 `CUR`, line 2 `LAP`.
  - Mode 2: line 1 `LAP`, line 2 `INT`.
  - Mode 3: line 1 `BST`, line 2 `AVG`.
- **Digit encoding.** A digit d≤9 is sent as 0x30+d. A digit >9 is sent as `?` (0x3F).
- **No lap recorded.** If the snapshot `lap_valid`=0, every LAP/INT/BST/AVG field shows `--:--.--`. The label is still printed. CUR always shows digits.
- **Writer protocol.** `wr_addr` and `wr_char` must hold stable while `wr_req`=1 and `wr_ack`=0. `wr_ack` while `wr_req`=0 is ignored.

## Timing
- **Reset values:** `wr_req`=0, `wr_addr`=0, `wr_char`=0x20, `busy`=0, `frame_done`=0, `ack_timeout`=0, state IDLE, `pending`=1.
- **Reset mid-frame:** all outputs return to their reset values immediately. After reset release a full frame restarts from address 0.
- **Event to first request:** the event is registered at edge N, LOAD occurs at N+1, and `wr_req` rises at N+2.
- **Throughput:** with `wr_ack` tied high, one character per cycle. A frame is 32 SEND cycles, then DONE. `frame_done` is high in the cycle after the ack for address 31.
- **`busy`:** high in LOAD, SEND and DONE. Low only in IDLE.
- **Next character:** after an ack, the next character is presented on the following edge. `wr_req` may stay high across characters.

## Configuration
- `LCD_SEQ_ACK_TIMEOUT_EN` defined:
  - An 8-bit counter runs while `wr_req`=1 and `wr_ack`=0. It clears on ack and on leaving SEND.
  - When it reaches `TIMEOUT_CYC`: drop `wr_req`, set `ack_timeout`=1, set `pending`=1, go to IDLE without a `frame_done` pulse. The frame then retries from address 0.
  - `ack_timeout` clears on the next `frame_done`.
- Macro undefined: no counter is built, `ack_timeout` is tied to 0, and SEND waits indefinitely.

## Test plan
- **Power-up draw.** `wr_ack`=1, mode 0, cur = 12:34.56, release reset. Expect 32 writes on addresses 0..31, line 1 `CUR 12:34.56    ` and line 2 all 0x20. `frame_done` fires exactly once and `busy` then drops.
- **No lap in mode 1.** Mode 1 with `lap_valid`=0, then flip `sw_update_toggle`. Expect line 2 `LAP --:--.--    `. Set `lap_valid`=1 with lap = 00:03.00 and toggle again. Expect line 2 `LAP 00:03.00    `.
- **Events during a frame.** Toggle 3 times and change mode once during one frame, while changing `cur_bcd` after LOAD. The current frame shows the snapshot values. Exactly one follow-up frame with the new values is sent, so `frame_done` fires twice in total.
- **Slow writer.** `wr_ack` asserted 3 cycles after each request. `wr_addr` and `wr_char` stay stable while waiting. The frame takes 32×4 SEND cycles, and no address is skipped or repeated.
- **Reset mid-frame.** Assert `rst_n`=0 at address 10. Outputs are at their reset values in the same cycle. After release, the frame restarts at address 0.
- **Timeout (macro defined).** `wr_ack` stuck low. After `TIMEOUT_CYC` cycles: `wr_req`=0 and `ack_timeout`=1, followed by a retry. Release `wr_ack`=1; the frame completes and `ack_timeout` returns to 0 at `frame_done`.
